// File: rtl/stage_if.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address, keeps a bimodal
// branch history table of 2-bit counters and applies redirects from
// decode (predicted taken) and execute (mispredict recovery).
//
// Stall/flush semantics of the IF/ID slot: valid_out=1 marks a real
// fetched instruction; valid_out=0 marks an injected NOP. The slot
// advances only when if_id_write=1; when if_id_write=0 every IF/ID output
// holds, except that an execute mispredict always flushes the slot.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BHT_IDX  = 6,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  input  logic        ex_resolve,
  input  logic [31:0] ex_pc,
  input  logic        ex_predict,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        predict_out,
  output logic        valid_out
);

  localparam int BHT_N = 1 << BHT_IDX;

  logic [31:0]        pc_q;
  logic [1:0]         bht [BHT_N];

  logic               mispredict;
  logic               id_flush;
  logic [31:0]        fix_pc;
  logic [31:0]        pc_next;
  logic [BHT_IDX-1:0] rd_idx;
  logic [BHT_IDX-1:0] wr_idx;
  logic [1:0]         wr_cnt;
  logic [1:0]         wr_cnt_next;
  logic               fetch_predict;

  assign imem_addr = pc_q;
  assign rd_idx    = pc_q[BHT_IDX+1:2];
  assign wr_idx    = ex_pc[BHT_IDX+1:2];

  // Prediction for the word being fetched; reads the pre-update counter.
  assign fetch_predict = bht[rd_idx][1];

  // Redirect decisions and next-PC selection, mispredict has top priority.
  always_comb begin
    mispredict = ex_resolve & (ex_predict != ex_taken);
    id_flush   = id_redirect & if_id_write;
    fix_pc     = ex_taken ? ex_target : (ex_pc + 32'd4);
    pc_next    = pc_q;
    if (mispredict) begin
      pc_next = fix_pc;
    end else if (id_flush) begin
      pc_next = id_target;
    end else if (pc_write) begin
      pc_next = pc_q + 32'd4;
    end
  end

  // Saturating counter update for the resolved branch.
  always_comb begin
    wr_cnt      = bht[wr_idx];
    wr_cnt_next = wr_cnt;
    if (ex_taken) begin
      if (wr_cnt != 2'b11) wr_cnt_next = wr_cnt + 2'b01;
    end else begin
      if (wr_cnt != 2'b00) wr_cnt_next = wr_cnt - 2'b01;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // IF/ID register: flush on redirect, hold on stall, otherwise capture fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out      <= 32'h0;
      inst_out    <= NOP_INST;
      predict_out <= 1'b0;
      valid_out   <= 1'b0;
    end else if (mispredict || id_flush) begin
      pc_out      <= pc_q;
      inst_out    <= NOP_INST;
      predict_out <= 1'b0;
      valid_out   <= 1'b0;
    end else if (if_id_write) begin
      pc_out      <= pc_q;
      inst_out    <= imem_data;
      predict_out <= fetch_predict;
      valid_out   <= 1'b1;
    end
  end

  // Branch history table: reset to weakly not-taken, trained on every resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (ex_resolve) begin
      bht[wr_idx] <= wr_cnt_next;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed scenarios with literal expectations plus
// randomized traffic, all compared against a behavioural fetch model.
module tb_stage_if;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        if_id_write;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        ex_resolve;
  logic [31:0] ex_pc;
  logic        ex_predict;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        predict_out;
  logic        valid_out;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_pc_out;
  logic [31:0] m_inst;
  logic        m_pred;
  logic        m_valid;
  logic        m_known;
  int          m_bht [64];

  stage_if dut (
    .clk         (clk),
    .rst         (rst),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .id_redirect (id_redirect),
    .id_target   (id_target),
    .ex_resolve  (ex_resolve),
    .ex_pc       (ex_pc),
    .ex_predict  (ex_predict),
    .ex_taken    (ex_taken),
    .ex_target   (ex_target),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .predict_out (predict_out),
    .valid_out   (valid_out)
  );

  // instruction memory: word content derived from its address
  assign imem_data = imem_addr ^ MASK;

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one rising edge
  task automatic model_step();
    logic        mis;
    logic [31:0] fix;
    logic        fpred;
    int          ui;
    if (rst) begin
      m_pc = 32'h0; m_pc_out = 32'h0; m_inst = NOP;
      m_pred = 1'b0; m_valid = 1'b0; m_known = 1'b1;
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      return;
    end
    mis   = ex_resolve && (ex_predict != ex_taken);
    fix   = ex_taken ? ex_target : ex_pc + 32'd4;
    fpred = (m_bht[(m_pc / 4) % 64] >= 2);
    if (mis || (id_redirect && if_id_write)) begin
      m_inst = NOP; m_valid = 1'b0; m_pred = 1'b0; m_known = 1'b0;
    end else if (if_id_write) begin
      m_pc_out = m_pc; m_inst = m_pc ^ MASK; m_pred = fpred;
      m_valid = 1'b1; m_known = 1'b1;
    end
    if (mis)                              m_pc = fix;
    else if (id_redirect && if_id_write)  m_pc = id_target;
    else if (pc_write)                    m_pc = m_pc + 32'd4;
    if (ex_resolve) begin
      ui = (ex_pc / 4) % 64;
      if (ex_taken) m_bht[ui] = (m_bht[ui] == 3) ? 3 : m_bht[ui] + 1;
      else          m_bht[ui] = (m_bht[ui] == 0) ? 0 : m_bht[ui] - 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // compare process: DUT outputs against the model, every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", imem_addr, m_pc);
      check("inst_out", inst_out, m_inst);
      check("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
      if (m_known) begin
        check("pc_out", pc_out, m_pc_out);
        check("predict_out", {31'h0, predict_out}, {31'h0, m_pred});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; pc_write = 1'b1; if_id_write = 1'b1; id_redirect = 1'b0;
    id_target = 32'h0; ex_resolve = 1'b0; ex_pc = 32'h0; ex_predict = 1'b0;
    ex_taken = 1'b0; ex_target = 32'h0;
  endtask

  task automatic rand_inputs();
    rst         = ($urandom_range(0, 99) == 0);
    pc_write    = ($urandom_range(0, 99) < 85);
    if_id_write = ($urandom_range(0, 99) < 85);
    id_redirect = ($urandom_range(0, 99) < 15);
    id_target   = $urandom_range(0, 255) << 2;
    ex_resolve  = ($urandom_range(0, 99) < 30);
    ex_pc       = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                              : ($urandom_range(0, 15) << 2);
    ex_predict  = $urandom_range(0, 1) == 1;
    ex_taken    = $urandom_range(0, 1) == 1;
    ex_target   = $urandom_range(0, 255) << 2;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    // reset state
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst pc_out", pc_out, 32'h0);
    check("rst inst_out", inst_out, NOP);
    check("rst valid", {31'h0, valid_out}, 32'h0);
    check("rst predict", {31'h0, predict_out}, 32'h0);

    // T1 sequential fetch
    idle();
    tick();
    check("t1 pc0", pc_out, 32'h0);
    check("t1 inst0", inst_out, 32'hA5A5_0000);
    check("t1 valid", {31'h0, valid_out}, 32'h1);
    tick();
    check("t1 pc4", pc_out, 32'h4);
    tick();
    check("t1 pc8", pc_out, 32'h8);
    tick();
    check("t1 addr10", imem_addr, 32'h10);

    // T2 stall two cycles
    pc_write = 1'b0; if_id_write = 1'b0;
    repeat (2) begin
      tick();
      check("t2 addr hold", imem_addr, 32'h10);
      check("t2 pc hold", pc_out, 32'hC);
      check("t2 inst hold", inst_out, 32'hC ^ MASK);
    end
    idle();
    tick();
    check("t2 pc10", pc_out, 32'h10);
    check("t2 addr14", imem_addr, 32'h14);

    // T3 decode redirect, then ignored redirect under stall
    repeat (4) tick();
    check("t3 addr24", imem_addr, 32'h24);
    id_redirect = 1'b1; id_target = 32'h80;
    tick();
    check("t3 addr80", imem_addr, 32'h80);
    check("t3 nop", inst_out, NOP);
    check("t3 valid0", {31'h0, valid_out}, 32'h0);
    if_id_write = 1'b0; id_target = 32'h200;
    tick();
    check("t3 ignored addr", imem_addr, 32'h84);
    check("t3 ignored valid", {31'h0, valid_out}, 32'h0);
    idle();
    tick();
    check("t3 pc84", pc_out, 32'h84);

    // T4 mispredict beats decode redirect and stalls
    ex_resolve = 1'b1; ex_pc = 32'h40; ex_predict = 1'b1; ex_taken = 1'b0;
    id_redirect = 1'b1; id_target = 32'h300; pc_write = 1'b0;
    tick();
    check("t4 addr44", imem_addr, 32'h44);
    check("t4 flush", inst_out, NOP);
    idle();
    tick();
    check("t4 valid", {31'h0, valid_out}, 32'h1);
    ex_resolve = 1'b1; ex_pc = 32'hFFFF_FFFC; ex_predict = 1'b1; ex_taken = 1'b0;
    pc_write = 1'b0; if_id_write = 1'b0;
    tick();
    check("t4 wrap fix", imem_addr, 32'h0);
    check("t4 flush stall", {31'h0, valid_out}, 32'h0);
    idle();
    ex_resolve = 1'b1; ex_pc = 32'hFFFF_FFFC; ex_predict = 1'b0; ex_taken = 1'b1;
    ex_target = 32'hFFFF_FFFC;
    tick();
    check("t4 taken tgt", imem_addr, 32'hFFFF_FFFC);
    idle();
    tick();
    check("t4 wrap pc4", imem_addr, 32'h0);
    check("t4 pc top", pc_out, 32'hFFFF_FFFC);

    // T5 counter training at 0x100
    idle();
    ex_resolve = 1'b1; ex_pc = 32'h100; ex_predict = 1'b1; ex_taken = 1'b1;
    repeat (3) tick();
    idle(); id_redirect = 1'b1; id_target = 32'h100;
    tick();
    idle();
    tick();
    check("t5 pc100", pc_out, 32'h100);
    check("t5 taken pred", {31'h0, predict_out}, 32'h1);
    ex_resolve = 1'b1; ex_pc = 32'h100; ex_predict = 1'b0; ex_taken = 1'b0;
    repeat (2) tick();
    idle(); id_redirect = 1'b1; id_target = 32'h100;
    tick();
    idle();
    tick();
    check("t5 nt pred", {31'h0, predict_out}, 32'h0);
    // same-index read and update in one cycle sees the old counter
    id_redirect = 1'b1; id_target = 32'h100;
    tick();
    idle();
    ex_resolve = 1'b1; ex_pc = 32'h100; ex_predict = 1'b1; ex_taken = 1'b1;
    tick();
    check("t5 no bypass", {31'h0, predict_out}, 32'h0);
    idle(); id_redirect = 1'b1; id_target = 32'h100;
    tick();
    idle();
    tick();
    check("t5 after upd", {31'h0, predict_out}, 32'h1);

    // T6 reset during stall with pending mispredict
    pc_write = 1'b0; if_id_write = 1'b0; ex_resolve = 1'b1; ex_pc = 32'h100;
    ex_predict = 1'b0; ex_taken = 1'b1; ex_target = 32'h500; rst = 1'b1;
    tick();
    check("t6 addr", imem_addr, 32'h0);
    check("t6 pc_out", pc_out, 32'h0);
    check("t6 inst", inst_out, NOP);
    check("t6 valid", {31'h0, valid_out}, 32'h0);
    idle();
    for (int i = 0; i < 64; i++) begin
      tick();
      check("t6 bht clear", {31'h0, predict_out}, 32'h0);
    end

    // randomized traffic
    repeat (3000) begin
      rand_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
